dma_pcie_crdt_tx: RTL and testbench

- Credit-managed transmit stage on the master side of the DMA-to-PCIe credit channel.
- Arbitrates NUM_CH per-channel source streams and drives tl_tdata/tl_tvld/tl_tch one beat per cycle.
- Keeps one credit counter per channel. Each issued beat costs one credit; each tl_crdt pulse returns one credit to channel tl_crdt_ch.
- Sits between the DMA engine's per-channel output queues and the PCIe-side credit sink.

---
 rtl/dma_pcie_crdt_pkg.sv | 24 ++
 rtl/dma_pcie_crdt_rr_arb.sv | 60 ++++++
 rtl/dma_pcie_crdt_tx.sv | 122 ++++++++++++
 tb/tb_dma_pcie_crdt_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pcie_crdt_pkg.sv
// ============================================================================
//  Module      : dma_pcie_crdt_pkg
//  Description : Shared defaults, helper function and types for the
//                DMA-to-PCIe credit-managed transmit stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pcie_crdt_pkg;

    localparam int DEF_DATA_BITS = 512;
    localparam int DEF_CH_BITS   = 2;
    localparam int DEF_INIT_CRDT = 8;
    localparam int DEF_CRDT_BITS = 4;

    typedef logic [DEF_CRDT_BITS-1:0] crdt_cnt_t;

    function automatic int num_ch(input int ch_bits);
        return 1 << ch_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_pcie_crdt_rr_arb.sv
// ============================================================================
//  Module      : dma_pcie_crdt_rr_arb
//  Description : N-way round-robin arbiter. One-hot grant, search starts at
//                the pointer; pointer moves past the winner on advance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_pcie_crdt_rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PTR_BITS = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_BITS = PTR_BITS + 1;
    localparam logic [IDX_BITS-1:0] c_n = IDX_BITS'(N);

    logic [PTR_BITS-1:0] r_ptr;
    logic [PTR_BITS-1:0] w_nxt_ptr;
    logic [IDX_BITS-1:0] w_idx;
    logic [IDX_BITS-1:0] w_idx_p1;
    logic                w_found;

    // Wrap is done explicitly so N need not be a power of two.
    always_comb begin
        gnt       = '0;
        w_nxt_ptr = r_ptr;
        w_found   = 1'b0;
        w_idx     = '0;
        w_idx_p1  = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, r_ptr} + IDX_BITS'(i);
            if (w_idx >= c_n) begin
                w_idx = w_idx - c_n;
            end
            if (!w_found && req[w_idx[PTR_BITS-1:0]]) begin
                w_found                  = 1'b1;
                gnt[w_idx[PTR_BITS-1:0]] = 1'b1;
                w_idx_p1                 = w_idx + 1'b1;
                w_nxt_ptr                = (w_idx_p1 == c_n) ? '0 : w_idx_p1[PTR_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= w_nxt_ptr;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_pcie_crdt_tx.sv
// ============================================================================
//  Module      : dma_pcie_crdt_tx
//  Description : Credit-managed transmit stage: round-robin arbitration of
//                per-channel streams with per-channel credit counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_pcie_crdt_tx
    import dma_pcie_crdt_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int CH_BITS   = DEF_CH_BITS,
    parameter int INIT_CRDT = DEF_INIT_CRDT,
    parameter int CRDT_BITS = DEF_CRDT_BITS
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [num_ch(CH_BITS)*DATA_BITS-1:0]      src_tdata,
    input  logic [num_ch(CH_BITS)-1:0]                src_tvalid,
    output logic [num_ch(CH_BITS)-1:0]                src_tready,
    output logic [DATA_BITS-1:0]                      tl_tdata,
    output logic                                      tl_tvld,
    output logic [CH_BITS-1:0]                        tl_tch,
    input  logic                                      tl_crdt,
    input  logic [CH_BITS-1:0]                        tl_crdt_ch,
    input  logic                                      crdt_reload,
    output logic [num_ch(CH_BITS)*CRDT_BITS-1:0]      crdt_cnt,
    output logic                                      crdt_ovf
);

    localparam int NUM_CH = num_ch(CH_BITS);
    localparam logic [CRDT_BITS-1:0] c_init = CRDT_BITS'(INIT_CRDT);

    logic [NUM_CH-1:0]    w_elig;
    logic [NUM_CH-1:0]    w_gnt;
    logic [NUM_CH-1:0]    w_ovf_hit;
    logic                 w_adv;
    logic [CH_BITS-1:0]   w_gidx;
    logic [DATA_BITS-1:0] w_gdata;

    logic [DATA_BITS-1:0] r_tdata;
    logic                 r_tvld;
    logic [CH_BITS-1:0]   r_tch;
    logic                 r_ovf;

    assign w_adv      = |w_gnt;
    assign src_tready = w_gnt;

    dma_pcie_crdt_rr_arb #(
        .N (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_elig),
        .advance (w_adv),
        .gnt     (w_gnt)
    );

    // Eligibility only looks at registered counts, so a returned credit is
    // usable from the following cycle.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CRDT_BITS-1:0] r_cnt;
        logic                 w_dec;
        logic                 w_inc;

        assign w_dec        = w_gnt[c];
        assign w_inc        = tl_crdt && (tl_crdt_ch == CH_BITS'(c));
        assign w_elig[c]    = src_tvalid[c] && (r_cnt != '0) && !crdt_reload;
        assign w_ovf_hit[c] = !crdt_reload && w_inc && !w_dec && (r_cnt == c_init);
        assign crdt_cnt[c*CRDT_BITS +: CRDT_BITS] = r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= c_init;
            end else if (crdt_reload) begin
                r_cnt <= c_init;
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (w_inc && !w_dec && (r_cnt != c_init)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_gidx  = '0;
        w_gdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_gnt[c]) begin
                w_gidx  = CH_BITS'(c);
                w_gdata = src_tdata[c*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tvld  <= 1'b0;
            r_tdata <= '0;
            r_tch   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_tvld <= w_adv;
            if (w_adv) begin
                r_tdata <= w_gdata;
                r_tch   <= w_gidx;
            end
            if (|w_ovf_hit) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign tl_tdata = r_tdata;
    assign tl_tvld  = r_tvld;
    assign tl_tch   = r_tch;
    assign crdt_ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_dma_pcie_crdt_tx.sv
// ============================================================================
//  Module      : tb_dma_pcie_crdt_tx
//  Description : Self-checking bench for dma_pcie_crdt_tx with a credit /
//                round-robin reference model, vector table and random run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_pcie_crdt_tx;

    localparam int DW   = 512;
    localparam int NCH  = 4;
    localparam int INIT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*DW-1:0] src_tdata;
    logic [NCH-1:0]    src_tvalid;
    logic [NCH-1:0]    src_tready;
    logic [DW-1:0]     tl_tdata;
    logic              tl_tvld;
    logic [1:0]        tl_tch;
    logic              tl_crdt;
    logic [1:0]        tl_crdt_ch;
    logic              crdt_reload;
    logic [NCH*4-1:0]  crdt_cnt;
    logic              crdt_ovf;

    always #5 clk = ~clk;

    dma_pcie_crdt_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_tdata   (src_tdata),
        .src_tvalid  (src_tvalid),
        .src_tready  (src_tready),
        .tl_tdata    (tl_tdata),
        .tl_tvld     (tl_tvld),
        .tl_tch      (tl_tch),
        .tl_crdt     (tl_crdt),
        .tl_crdt_ch  (tl_crdt_ch),
        .crdt_reload (crdt_reload),
        .crdt_cnt    (crdt_cnt),
        .crdt_ovf    (crdt_ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_cnt [NCH];
    int          m_ptr;
    bit          m_ovf;
    bit          m_tvld;
    int          m_tch;
    logic [DW-1:0] m_tdata;
    logic [DW-1:0] drv_data [NCH];
    logic [NCH-1:0] obs_ready;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_state();
        chk("tl_tvld", DW'(tl_tvld), DW'(m_tvld));
        chk("tl_tch", DW'(tl_tch), DW'(m_tch));
        chk("tl_tdata", tl_tdata, m_tdata);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("crdt_cnt[%0d]", c), DW'(crdt_cnt[c*4 +: 4]), DW'(m_cnt[c]));
        end
        chk("crdt_ovf", DW'(crdt_ovf), DW'(m_ovf));
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) m_cnt[c] = INIT;
        m_ptr   = 0;
        m_ovf   = 0;
        m_tvld  = 0;
        m_tch   = 0;
        m_tdata = '0;
    endfunction

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic step(input logic [NCH-1:0] v, input logic cr, input logic [1:0] cch, input logic rl);
        int g;
        logic [NCH-1:0] exp_ready;
        src_tvalid  = v;
        tl_crdt     = cr;
        tl_crdt_ch  = cch;
        crdt_reload = rl;
        for (int c = 0; c < NCH; c++) begin
            for (int w = 0; w < DW/32; w++) drv_data[c][w*32 +: 32] = $urandom;
            src_tdata[c*DW +: DW] = drv_data[c];
        end
        g = -1;
        if (!rl) begin
            for (int k = 0; k < NCH; k++) begin
                int ch;
                ch = (m_ptr + k) % NCH;
                if (g < 0 && v[ch] && m_cnt[ch] > 0) g = ch;
            end
        end
        exp_ready = (g >= 0) ? NCH'(1 << g) : '0;
        #1;
        obs_ready = src_tready;
        chk("src_tready", DW'(src_tready), DW'(exp_ready));
        @(posedge clk);
        #1;
        if (rl) begin
            for (int c = 0; c < NCH; c++) m_cnt[c] = INIT;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bit dec, inc;
                dec = (g == c);
                inc = cr && (cch == c);
                if (dec && !inc) m_cnt[c]--;
                else if (inc && !dec) begin
                    if (m_cnt[c] == INIT) m_ovf = 1;
                    else m_cnt[c]++;
                end
            end
        end
        if (g >= 0) begin
            m_tvld  = 1;
            m_tch   = g;
            m_tdata = drv_data[g];
            m_ptr   = (g + 1) % NCH;
        end else begin
            m_tvld = 0;
        end
        check_state();
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        rst_n       = 1'b0;
        src_tvalid  = '0;
        tl_crdt     = 1'b0;
        tl_crdt_ch  = '0;
        crdt_reload = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] v;
        logic       cr;
        logic [1:0] cch;
        logic       rl;
        logic [3:0] e_ready;
        logic       e_tvld;
        logic [1:0] e_tch;
        logic       e_ovf;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int beats;
        src_tdata = '0;

        tbl[0] = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[1] = '{4'b0001, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[2] = '{4'b1010, 1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[3] = '{4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[4] = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[5] = '{4'b1001, 1'b0, 2'd0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[6] = '{4'b1001, 1'b1, 2'd3, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[7] = '{4'b0100, 1'b1, 2'd2, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[8] = '{4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1};

        // Reset values
        do_reset();
        check_state();

        // Vector table
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].cr, tbl[i].cch, tbl[i].rl);
            chk($sformatf("tbl%0d ready", i), DW'(obs_ready), DW'(tbl[i].e_ready));
            chk($sformatf("tbl%0d tvld", i), DW'(tl_tvld), DW'(tbl[i].e_tvld));
            chk($sformatf("tbl%0d tch", i), DW'(tl_tch), DW'(tbl[i].e_tch));
            chk($sformatf("tbl%0d ovf", i), DW'(crdt_ovf), DW'(tbl[i].e_ovf));
        end

        // All channels request: 32 beats in 0,1,2,3 order, then starvation
        do_reset();
        for (int k = 0; k < 32; k++) begin
            step(4'b1111, 1'b0, 2'd0, 1'b0);
            chk("rr tch", DW'(tl_tch), DW'(k % 4));
            chk("rr tvld", DW'(tl_tvld), DW'(1));
        end
        step(4'b1111, 1'b0, 2'd0, 1'b0);
        chk("drained ready", DW'(obs_ready), DW'(0));
        chk("drained tvld", DW'(tl_tvld), DW'(0));
        chk("drained cnt", DW'(crdt_cnt), DW'(0));

        // Channel 2 alone: 8 beats, then one credit gives one more beat two cycles later
        do_reset();
        beats = 0;
        for (int k = 0; k < 10; k++) begin
            step(4'b0100, 1'b0, 2'd0, 1'b0);
            if (tl_tvld && tl_tch == 2'd2) beats++;
        end
        chk("ch2 beats", DW'(beats), DW'(8));
        step(4'b0100, 1'b1, 2'd2, 1'b0);
        chk("ch2 N+1 tvld", DW'(tl_tvld), DW'(0));
        step(4'b0100, 1'b0, 2'd0, 1'b0);
        chk("ch2 N+2 tvld", DW'(tl_tvld), DW'(1));
        chk("ch2 N+2 tch", DW'(tl_tch), DW'(2));
        step(4'b0100, 1'b0, 2'd0, 1'b0);
        chk("ch2 N+3 tvld", DW'(tl_tvld), DW'(0));

        // Channel 1 at 3 credits: simultaneous grant and return
        do_reset();
        for (int k = 0; k < 5; k++) step(4'b0010, 1'b0, 2'd0, 1'b0);
        chk("ch1 cnt3", DW'(crdt_cnt[7:4]), DW'(3));
        step(4'b0010, 1'b1, 2'd1, 1'b0);
        chk("ch1 net zero cnt", DW'(crdt_cnt[7:4]), DW'(3));
        chk("ch1 net zero tvld", DW'(tl_tvld), DW'(1));

        // Overflow is sticky through reload, cleared by reset
        do_reset();
        step(4'b0000, 1'b1, 2'd0, 1'b0);
        chk("ovf set", DW'(crdt_ovf), DW'(1));
        chk("ovf cnt0", DW'(crdt_cnt[3:0]), DW'(8));
        step(4'b0000, 1'b0, 2'd0, 1'b1);
        chk("ovf after reload", DW'(crdt_ovf), DW'(1));
        do_reset();
        chk("ovf after reset", DW'(crdt_ovf), DW'(0));

        // Reload with concurrent return and request on ch3 at 2 credits
        for (int k = 0; k < 6; k++) step(4'b1000, 1'b0, 2'd0, 1'b0);
        chk("ch3 cnt2", DW'(crdt_cnt[15:12]), DW'(2));
        step(4'b1000, 1'b1, 2'd3, 1'b1);
        chk("reload ready", DW'(obs_ready), DW'(0));
        chk("reload tvld", DW'(tl_tvld), DW'(0));
        chk("reload cnt", DW'(crdt_cnt), DW'(16'h8888));

        // Asynchronous reset while a beat is on the output
        for (int k = 0; k < 3; k++) step(4'b1111, 1'b0, 2'd0, 1'b0);
        chk("pre-reset tvld", DW'(tl_tvld), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst tvld", DW'(tl_tvld), DW'(0));
        chk("async rst cnt", DW'(crdt_cnt), DW'(16'h8888));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1111, 1'b0, 2'd0, 1'b0);
        chk("post-reset grant", DW'(obs_ready), DW'(4'b0001));

        // Randomized run against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] v;
            logic       cr;
            logic [1:0] cch;
            logic       rl;
            v   = 4'($urandom);
            cr  = ($urandom_range(0, 99) < 45);
            cch = 2'($urandom);
            rl  = ($urandom_range(0, 99) < 2);
            step(v, cr, cch, rl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
